// File: rtl/rv32i_types.sv
// Shared RV32I encodings used by the memory/writeback stage.
// Also holds the alignment rule common to loads and stores.
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  // Loads and stores share the low two funct3 bits for the access size.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword from a cache word and extends it
// according to the load width code.
module load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      LB:      result_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      result_o = {{16{half_sel[15]}}, half_sel};
      LBU:     result_o = {24'd0, byte_sel};
      LHU:     result_o = {16'd0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues data-cache requests for loads/stores,
// aligns load data and drives the register-file write port.
//
// state  | meaning
// IDLE   | no instruction held, ready for a new one
// ACCESS | cache request outstanding, waiting for data_mem_resp
// WB     | instruction retires this cycle, ready for the next one
module mem_wb_stage
  import rv32i_types::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic                 load_en,
  input  logic                 store_en,
  input  logic                 regwrite_in,
  input  logic [2:0]           funct3_in,
  input  logic [4:0]           rd_in,
  input  logic [31:0]          alu_out,
  input  logic [31:0]          rs2_out,
  output logic                 data_mem_read,
  output logic                 data_mem_write,
  output logic [31:0]          data_mem_address,
  output logic [31:0]          data_mem_wdata,
  output logic [3:0]           data_mem_byte_enable,
  input  logic [31:0]          data_mem_rdata,
  input  logic                 data_mem_resp,
  output logic                 rf_load,
  output logic [4:0]           rf_rd,
  output logic [31:0]          rf_wdata,
  output logic                 misalign_err,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WB
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t state_q, state_d;

  logic                 load_q, store_q, regwrite_q, misalign_q;
  logic [2:0]           funct3_q;
  logic [4:0]           rd_q;
  logic [31:0]          alu_q, rs2_q, rdata_q;
  logic [CNT_WIDTH-1:0] retired_q, stall_q;
  logic                 accept, mem_op_in, misalign_in;
  logic [1:0]           off;
  logic [31:0]          load_result;

  assign accept      = valid_in && ready_out;
  assign mem_op_in   = load_en || store_en;
  assign misalign_in = mem_op_in && is_misaligned(funct3_in, alu_out[1:0]);

  always_comb begin
    state_d   = state_q;
    ready_out = (state_q != S_ACCESS);
    case (state_q)
      S_IDLE, S_WB: begin
        if (accept) begin
          state_d = (mem_op_in && !misalign_in) ? S_ACCESS : S_WB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (data_mem_resp) state_d = S_WB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      regwrite_q <= 1'b0;
      misalign_q <= 1'b0;
      funct3_q   <= 3'd0;
      rd_q       <= 5'd0;
      alu_q      <= 32'd0;
      rs2_q      <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      if (accept) begin
        load_q     <= load_en;
        store_q    <= store_en;
        regwrite_q <= regwrite_in;
        misalign_q <= misalign_in;
        funct3_q   <= funct3_in;
        rd_q       <= rd_in;
        alu_q      <= alu_out;
        rs2_q      <= rs2_out;
      end
      // A response seen outside ACCESS belongs to nothing and is dropped.
      if (state_q == S_ACCESS && data_mem_resp) begin
        rdata_q <= data_mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (state_q == S_WB)     retired_q <= retired_q + CNT_ONE;
      if (state_q == S_ACCESS) stall_q   <= stall_q + CNT_ONE;
    end
  end

  assign off              = alu_q[1:0];
  assign data_mem_read    = (state_q == S_ACCESS) && load_q;
  assign data_mem_write   = (state_q == S_ACCESS) && store_q;
  assign data_mem_address = {alu_q[31:2], 2'b00};
  assign data_mem_wdata   = rs2_q << {off, 3'b000};

  always_comb begin
    case (funct3_q)
      SB:      data_mem_byte_enable = 4'b0001 << off;
      SH:      data_mem_byte_enable = 4'b0011 << off;
      default: data_mem_byte_enable = 4'b1111;
    endcase
  end

  load_align u_load_align (
    .rdata_i  (rdata_q),
    .off_i    (off),
    .funct3_i (funct3_q),
    .result_o (load_result)
  );

  assign rf_load       = (state_q == S_WB) && regwrite_q && (rd_q != 5'd0) && !misalign_q;
  assign rf_rd         = rd_q;
  assign rf_wdata      = load_q ? load_result : alu_q;
  assign misalign_err  = (state_q == S_WB) && misalign_q;
  assign retired_count = retired_q;
  assign stall_count   = stall_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed instructions push expected
// cache requests and writebacks; a cache model and a writeback monitor check them.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, load_en, store_en, regwrite_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic [31:0] alu_out, rs2_out, data_mem_rdata;
  logic        data_mem_resp;

  logic        ready_out, data_mem_read, data_mem_write, rf_load, misalign_err;
  logic [31:0] data_mem_address, data_mem_wdata, rf_wdata;
  logic [3:0]  data_mem_byte_enable;
  logic [4:0]  rf_rd;
  logic [31:0] retired_count, stall_count;

  logic        d4_ready, d4_read, d4_write, d4_rf_load, d4_mis;
  logic [31:0] d4_addr, d4_wdata, d4_rf_wdata;
  logic [3:0]  d4_be, d4_retired, d4_stall;
  logic [4:0]  d4_rf_rd;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .load_en(load_en), .store_en(store_en), .regwrite_in(regwrite_in),
    .funct3_in(funct3_in), .rd_in(rd_in), .alu_out(alu_out), .rs2_out(rs2_out),
    .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
    .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata),
    .data_mem_byte_enable(data_mem_byte_enable), .data_mem_rdata(data_mem_rdata),
    .data_mem_resp(data_mem_resp), .rf_load(rf_load), .rf_rd(rf_rd),
    .rf_wdata(rf_wdata), .misalign_err(misalign_err),
    .retired_count(retired_count), .stall_count(stall_count)
  );

  mem_wb_stage #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(d4_ready),
    .load_en(load_en), .store_en(store_en), .regwrite_in(regwrite_in),
    .funct3_in(funct3_in), .rd_in(rd_in), .alu_out(alu_out), .rs2_out(rs2_out),
    .data_mem_read(d4_read), .data_mem_write(d4_write),
    .data_mem_address(d4_addr), .data_mem_wdata(d4_wdata),
    .data_mem_byte_enable(d4_be), .data_mem_rdata(data_mem_rdata),
    .data_mem_resp(data_mem_resp), .rf_load(d4_rf_load), .rf_rd(d4_rf_rd),
    .rf_wdata(d4_rf_wdata), .misalign_err(d4_mis),
    .retired_count(d4_retired), .stall_count(d4_stall)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
  } creq_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wdata;
    bit          mis;
  } wb_t;

  creq_t cq[$];
  wb_t   sbq[$];
  int    ld_cyc[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit cbusy = 1'b0;
  int late_req = 0;
  int exp_ret = 0;
  int exp_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout waiting on DUT", nm);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Cache model: checks each request against the expected queue and
  // answers after the listed latency.
  initial begin
    creq_t cur;
    int k = 0;
    int late_seen = 0;
    cur = '{we: 1'b0, addr: 32'd0, be: 4'd0, wdata: 32'd0, lat: 0, rdata: 32'd0};
    forever begin
      @(negedge clk);
      data_mem_resp = 1'b0;
      if (late_req != late_seen) begin
        late_seen      = late_req;
        data_mem_resp  = 1'b1;
        data_mem_rdata = 32'hFFFF_FFFF;
      end else if (data_mem_read || data_mem_write) begin
        if (!cbusy) begin
          if (cq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_req: got rd=%b wr=%b addr %h expected no request",
                     data_mem_read, data_mem_write, data_mem_address);
          end else begin
            cur   = cq.pop_front();
            cbusy = 1'b1;
            k     = 0;
            chk("req_write", {31'd0, data_mem_write}, {31'd0, cur.we});
            chk("req_read", {31'd0, data_mem_read}, {31'd0, !cur.we});
            chk("req_addr", data_mem_address, cur.addr);
            if (cur.we) begin
              chk("req_be", {28'd0, data_mem_byte_enable}, {28'd0, cur.be});
              chk("req_wdata", data_mem_wdata, cur.wdata);
            end
          end
        end else begin
          chk("hold_addr", data_mem_address, cur.addr);
          if (cur.we) begin
            chk("hold_be", {28'd0, data_mem_byte_enable}, {28'd0, cur.be});
            chk("hold_wdata", data_mem_wdata, cur.wdata);
          end
        end
        if (cbusy) begin
          k++;
          if (k > cur.lat) begin
            chk("strobe_after_resp", 32'd1, 32'd0);
          end else if (k == cur.lat) begin
            data_mem_resp  = 1'b1;
            data_mem_rdata = cur.rdata;
          end
        end
      end else if (cbusy) begin
        if (!rst && k < cur.lat) chk("strobe_dropped_early", k, cur.lat);
        cbusy = 1'b0;
      end
    end
  end

  // Writeback monitor.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (!rst && (rf_load || misalign_err)) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_wb: got rf_load=%b mis=%b rd %0d expected none",
                   rf_load, misalign_err, rf_rd);
        end else begin
          e = sbq.pop_front();
          if (e.mis) begin
            chk("mis_err", {31'd0, misalign_err}, 32'd1);
            chk("mis_rf_load", {31'd0, rf_load}, 32'd0);
          end else begin
            chk("wb_rd", {27'd0, rf_rd}, {27'd0, e.rd});
            chk("wb_wdata", rf_wdata, e.wdata);
            chk("wb_no_mis", {31'd0, misalign_err}, 32'd0);
            ld_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic issue(input bit ld, input bit st, input bit rw, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rs2,
                       output int tries);
    bit acc;
    acc         = 1'b0;
    tries       = 0;
    valid_in    = 1'b1;
    load_en     = ld;
    store_en    = st;
    regwrite_in = rw;
    funct3_in   = f3;
    rd_in       = rd;
    alu_out     = alu;
    rs2_out     = rs2;
    while (!acc && tries < 100) begin
      acc = ready_out;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) bound_fail("accept");
    valid_in = 1'b0;
  endtask

  task automatic mem_op(input bit ld, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] rs2, input int lat,
                        input logic [31:0] rdata, input logic [3:0] be,
                        input logic [31:0] exp_w, output int tries);
    cq.push_back('{we: !ld, addr: {addr[31:2], 2'b00}, be: be, wdata: exp_w, lat: lat, rdata: rdata});
    if (ld && rd != 5'd0) sbq.push_back('{rd: rd, wdata: exp_w, mis: 1'b0});
    exp_stall += lat;
    exp_ret++;
    issue(ld, !ld, ld, f3, rd, addr, rs2, tries);
  endtask

  task automatic wait_done();
    int g = 0;
    while ((sbq.size() != 0 || cq.size() != 0 || cbusy) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) bound_fail("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counters(input string nm);
    chk({nm, "_retired"}, retired_count, exp_ret);
    chk({nm, "_stall"}, stall_count, exp_stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; valid_in = 1'b0; load_en = 1'b0; store_en = 1'b0; regwrite_in = 1'b0;
    funct3_in = 3'd0; rd_in = 5'd0; alu_out = 32'd0; rs2_out = 32'd0;
    data_mem_rdata = 32'd0; data_mem_resp = 1'b0;
    #3;
    chk("rst_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_read", {31'd0, data_mem_read}, 32'd0);
    chk("rst_rf_load", {31'd0, rf_load}, 32'd0);
    chk("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk_counters("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // lb at 0x1003: top byte 0x80 sign-extends
    mem_op(1, 3'b000, 5'd5, 32'h0000_1003, 32'd0, 3, 32'h80FF_FFFF, 4'b0000, 32'hFFFF_FF80, t);
    chk("first_accept_tries", t, 1);
    wait_done();
    chk_counters("lb");

    // sh at 0x2002
    mem_op(0, 3'b001, 5'd0, 32'h0000_2002, 32'h0000_BEEF, 2, 32'd0, 4'b1100, 32'hBEEF_0000, t);
    wait_done();
    chk_counters("sh");

    // misaligned lw at 0x3001
    sbq.push_back('{rd: 5'd9, wdata: 32'd0, mis: 1'b1});
    exp_ret++;
    issue(1, 0, 1, 3'b010, 5'd9, 32'h0000_3001, 32'd0, t);
    wait_done();
    chk_counters("lw_mis");

    mem_op(1, 3'b101, 5'd10, 32'h0000_5002, 32'd0, 1, 32'h8001_2345, 4'b0000, 32'h0000_8001, t);
    mem_op(1, 3'b001, 5'd11, 32'h0000_5000, 32'd0, 2, 32'h1234_F00D, 4'b0000, 32'hFFFF_F00D, t);
    mem_op(0, 3'b000, 5'd0, 32'h0000_6001, 32'h1234_56AB, 1, 32'd0, 4'b0010, 32'h3456_AB00, t);
    mem_op(0, 3'b010, 5'd0, 32'h0000_6004, 32'hCAFE_F00D, 2, 32'd0, 4'b1111, 32'hCAFE_F00D, t);
    mem_op(1, 3'b100, 5'd12, 32'h0000_7002, 32'd0, 1, 32'h00CD_0000, 4'b0000, 32'h0000_00CD, t);
    mem_op(1, 3'b010, 5'd0, 32'h0000_7000, 32'd0, 1, 32'hDEAD_BEEF, 4'b0000, 32'd0, t);
    wait_done();
    chk_counters("mixed");

    // four back-to-back ALU results
    for (int i = 1; i <= 4; i++) begin
      sbq.push_back('{rd: 5'd1, wdata: 32'(i), mis: 1'b0});
      exp_ret++;
      issue(0, 0, 1, 3'b000, 5'd1, 32'(i), 32'd0, t);
      if (i > 1) chk("b2b_accept_tries", t, 1);
    end
    wait_done();
    if (ld_cyc.size() >= 4) chk("b2b_consecutive", ld_cyc[ld_cyc.size()-1] - ld_cyc[ld_cyc.size()-4], 3);
    else bound_fail("b2b_consecutive");
    chk_counters("b2b");
    chk("cnt4_retired_wrap", {28'd0, d4_retired}, exp_ret % 16);

    // reset two cycles into a slow load
    mem_op(1, 3'b010, 5'd7, 32'h0000_4000, 32'd0, 50, 32'h1111_2222, 4'b0000, 32'h1111_2222, t);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_read", {31'd0, data_mem_read}, 32'd0);
    chk("rst_mid_ready", {31'd0, ready_out}, 32'd1);
    chk("rst_mid_retired", retired_count, 32'd0);
    chk("rst_mid_stall", stall_count, 32'd0);
    sbq.delete();
    exp_ret = 0;
    exp_stall = 0;
    @(negedge clk);
    #1 rst = 1'b0;
    late_req++;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("late_resp_ready", {31'd0, ready_out}, 32'd1);
    chk("late_resp_read", {31'd0, data_mem_read}, 32'd0);
    @(posedge clk);
    #1;
    chk_counters("late_resp");
    chk("late_resp_rf_load", {31'd0, rf_load}, 32'd0);

    // 17 retirements: 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      issue(0, 0, 0, 3'b000, 5'd0, 32'(i + 100), 32'd0, t);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("ret17_main", retired_count, 32'd17);
    chk("ret17_cnt4", {28'd0, d4_retired}, 32'd1);
    chk("ret17_stall4", {28'd0, d4_stall}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
